counter: RTL and testbench

- Free-running, parameterisable up-counter; presents its current count on a single output bus.
- Generic leaf block used wherever a cycle/event count or simple timebase is needed.
- One clock domain; synchronous active-low reset.
- No enable or load; counts on every clock edge while out of reset.

---
 rtl/counter_pkg.sv | 27 ++
 rtl/counter_next.sv | 28 ++
 rtl/counter.sv | 40 ++++
 tb/tb_counter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and parameter helpers for the free-running counter family.
package counter_pkg;

    localparam int COUNTER_DEFAULT_WIDTH = 8;

    // All-ones value for a w-bit count, safe for w = 64 where a shift would overflow.
    function automatic logic [63:0] max_for_width(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic bit params_legal(input int w,
                                        input logic [63:0] reset_value,
                                        input logic [63:0] step,
                                        input logic [63:0] max_value);
        bit ok;
        ok = 1'b1;
        if (w < 1 || w > 64) ok = 1'b0;
        if (max_value > max_for_width(w)) ok = 1'b0;
        if (reset_value > max_value) ok = 1'b0;
        if (step < 64'd1 || step > max_for_width(w)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count: add STEP at WIDTH+1 bits, wrap into [RESET_VALUE, MAX_VALUE].
module counter_next
    import counter_pkg::*;
#(
    parameter int          WIDTH       = COUNTER_DEFAULT_WIDTH,
    parameter logic [63:0] RESET_VALUE = 64'd0,
    parameter logic [63:0] STEP        = 64'd1,
    parameter logic [63:0] MAX_VALUE   = max_for_width(WIDTH)
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0] RST_X  = (WIDTH+1)'(RESET_VALUE);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] wrapped;

    always_comb begin
        sum     = {1'b0, cur} + STEP_X;
        // Overshoot past MAX_VALUE re-enters the range starting at RESET_VALUE.
        wrapped = RST_X + (sum - MAX_X - 1'b1);
        nxt     = (sum > MAX_X) ? wrapped[WIDTH-1:0] : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/counter.sv
// Free-running parameterisable up-counter with synchronous active-low reset.
module counter
    import counter_pkg::*;
#(
    parameter int          WIDTH       = COUNTER_DEFAULT_WIDTH,
    parameter logic [63:0] RESET_VALUE = 64'd0,
    parameter logic [63:0] STEP        = 64'd1,
    parameter logic [63:0] MAX_VALUE   = max_for_width(WIDTH)
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             rst
);

    if (!params_legal(WIDTH, RESET_VALUE, STEP, MAX_VALUE)) begin : g_param_check
        $error("counter: illegal WIDTH/RESET_VALUE/STEP/MAX_VALUE combination");
    end

    logic [WIDTH-1:0] nxt;

    counter_next #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .STEP        (STEP),
        .MAX_VALUE   (MAX_VALUE)
    ) u_next (
        .cur (value),
        .nxt (nxt)
    );

    // Reset wins over counting on any edge where rst is sampled low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= WIDTH'(RESET_VALUE);
        end else begin
            value <= nxt;
        end
    end

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default 8-bit instance plus a WIDTH=4 wrapping instance.
module tb_counter;

    logic       clk;
    logic       rst_a;
    logic       rst_b;
    logic [7:0] val_a;
    logic [3:0] val_b;
    logic       probe;

    int n_checks;
    int n_pass;

    counter u_a (
        .value (val_a),
        .clk   (clk),
        .rst   (rst_a)
    );

    counter #(
        .WIDTH       (4),
        .RESET_VALUE (64'd3),
        .STEP        (64'd4),
        .MAX_VALUE   (64'd12)
    ) u_b (
        .value (val_b),
        .clk   (clk),
        .rst   (rst_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        probe    = 1'bx;
        rst_a    = 1'b1;
        rst_b    = 1'b0;

        // Power-up: only meaningful where the simulator models X.
        tick();
        if ($isunknown(probe)) begin
            chk("powerup_x", 64'($isunknown(val_a)), 64'd1);
        end

        // Reset held for two edges, then count.
        rst_a = 1'b0;
        tick(); chk("rst_edge1", 64'(val_a), 64'h00);
        tick(); chk("rst_edge2", 64'(val_a), 64'h00);
        rst_a = 1'b1;
        tick(); chk("count1", 64'(val_a), 64'h01);
        tick(); chk("count2", 64'(val_a), 64'h02);
        tick(); chk("count3", 64'(val_a), 64'h03);

        // Full 256-edge run from reset.
        rst_a = 1'b0;
        tick(); chk("wrap_rst", 64'(val_a), 64'h00);
        rst_a = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 1)   chk("wrap_e1",   64'(val_a), 64'h01);
            if (i == 128) chk("wrap_e128", 64'(val_a), 64'h80);
            if (i == 255) chk("wrap_e255", 64'(val_a), 64'hFF);
            if (i == 256) chk("wrap_e256", 64'(val_a), 64'h00);
        end

        // Mid-count reset, with rst glitching between edges first.
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("mid_at5", 64'(val_a), 64'h05);
        rst_a = 1'b0; #2;
        rst_a = 1'b1; #2;
        rst_a = 1'b0; #1;
        chk("sync_hold", 64'(val_a), 64'h05);
        rst_a = 1'b1; #1;
        chk("sync_hold2", 64'(val_a), 64'h05);
        rst_a = 1'b0;
        tick(); chk("mid_rst", 64'(val_a), 64'h00);
        rst_a = 1'b1;
        tick(); chk("mid_resume", 64'(val_a), 64'h01);

        // Boot sequence: low 17 ns, high 11 ns, low 29 ns, then high.
        fork
            begin
                rst_a = 1'b0; #17;
                rst_a = 1'b1; #11;
                rst_a = 1'b0; #29;
                rst_a = 1'b1;
            end
            begin
                tick(); chk("boot_p1",   64'(val_a), 64'h00);
                tick(); chk("boot_gap",  64'(val_a), 64'h01);
                tick(); chk("boot_p2a",  64'(val_a), 64'h00);
                tick(); chk("boot_p2b",  64'(val_a), 64'h00);
                tick(); chk("boot_p2c",  64'(val_a), 64'h00);
                tick(); chk("boot_run1", 64'(val_a), 64'h01);
                tick(); chk("boot_run2", 64'(val_a), 64'h02);
            end
        join

        // WIDTH=4, RESET_VALUE=3, MAX_VALUE=12, STEP=4: 11+4=15 wraps to 3+(15-12-1)=5.
        rst_b = 1'b0;
        tick(); chk("b_rst", 64'(val_b), 64'd3);
        rst_b = 1'b1;
        tick(); chk("b_c1", 64'(val_b), 64'd7);
        tick(); chk("b_c2", 64'(val_b), 64'd11);
        tick(); chk("b_wrap1", 64'(val_b), 64'd5);
        tick(); chk("b_c4", 64'(val_b), 64'd9);
        tick(); chk("b_wrap2", 64'(val_b), 64'd3);
        tick(); chk("b_c6", 64'(val_b), 64'd7);
        rst_b = 1'b0;
        tick(); chk("b_rst2", 64'(val_b), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
